// File: rtl/sevenseg_scan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sevenseg_scan: time-multiplexed common-anode seven-segment driver with   |
// | per-digit blanking gap, frame-latched shadow inputs and leading-zero     |
// | suppression.                                                             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sevenseg_scan #(
  parameter int DIGITS       = 4,
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value_i,
  input  logic [DIGITS-1:0]     dp_i,
  input  logic                  lz_en_i,
  output logic [6:0]            seg_no,
  output logic                  dp_no,
  output logic [DIGITS-1:0]     an_no,
  output logic                  frame_o
);

  localparam int MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam int IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [4*DIGITS-1:0]   shadow_val_q, shadow_val_d;
  logic [DIGITS-1:0]     shadow_dp_q, shadow_dp_d;
  logic                  shadow_lz_q, shadow_lz_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic                  frame_q, frame_d;

  logic                  load;
  logic                  zero_above;
  logic                  suppress;
  logic [3:0]            nibble;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0:    hex7 = 7'b1000000;
      4'h1:    hex7 = 7'b1111001;
      4'h2:    hex7 = 7'b0100100;
      4'h3:    hex7 = 7'b0110000;
      4'h4:    hex7 = 7'b0011001;
      4'h5:    hex7 = 7'b0010010;
      4'h6:    hex7 = 7'b0000010;
      4'h7:    hex7 = 7'b1111000;
      4'h8:    hex7 = 7'b0000000;
      4'h9:    hex7 = 7'b0010000;
      4'hA:    hex7 = 7'b0001000;
      4'hB:    hex7 = 7'b0000011;
      4'hC:    hex7 = 7'b1000110;
      4'hD:    hex7 = 7'b0100001;
      4'hE:    hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q + CNT_W'(1);
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    shadow_lz_d  = shadow_lz_q;
    load         = 1'b0;

    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_ON;
          cnt_d   = '0;
          load    = (idx_q == '0);
        end
      end
      default: begin
        if (cnt_q == ON_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
      end
    endcase

    // Loading bypasses into the output decode so the first lit digit of a
    // frame already reflects the freshly captured inputs.
    if (load) begin
      shadow_val_d = value_i;
      shadow_dp_d  = dp_i;
      shadow_lz_d  = lz_en_i;
    end

    zero_above = 1'b1;
    suppress   = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above & (shadow_val_d[4*k +: 4] == 4'h0);
      if ((k > 0) && (k == int'(idx_d))) begin
        suppress = shadow_lz_d & zero_above;
      end
    end

    nibble  = shadow_val_d[{idx_d, 2'b00} +: 4];
    frame_d = (state_d == ST_BLANK) && (idx_d == '0) && (cnt_d == BLANK_LAST);
    seg_d   = '1;
    dp_d    = 1'b1;
    an_d    = '1;
    if (state_d == ST_ON) begin
      dp_d = ~shadow_dp_d[idx_d];
      if (!suppress) begin
        an_d  = ~(DIGITS'(1) << idx_d);
        seg_d = hex7(nibble);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_BLANK;
      idx_q        <= '0;
      cnt_q        <= '0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      shadow_lz_q  <= 1'b0;
      seg_q        <= '1;
      dp_q         <= 1'b1;
      an_q         <= '1;
      frame_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      shadow_lz_q  <= shadow_lz_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_q      <= frame_d;
    end
  end

  assign seg_no  = seg_q;
  assign dp_no   = dp_q;
  assign an_no   = an_q;
  assign frame_o = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_scan.sv
`default_nettype none
// Scoreboard bench for sevenseg_scan: a time-position reference model pushes
// the expected pin state per cycle, a negedge monitor pops and compares.
module tb_sevenseg_scan;
  localparam int DIGITS       = 4;
  localparam int DIGIT_CYCLES = 4;
  localparam int BLANK_CYCLES = 2;
  localparam int SLOT         = DIGIT_CYCLES + BLANK_CYCLES;
  localparam int FRAME        = DIGITS * SLOT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value_i = 16'h0;
  logic [3:0]  dp_i = 4'h0;
  logic        lz_en_i = 1'b0;
  logic [6:0]  seg_no;
  logic        dp_no;
  logic [3:0]  an_no;
  logic        frame_o;

  sevenseg_scan #(
    .DIGITS      (DIGITS),
    .DIGIT_CYCLES(DIGIT_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .value_i(value_i),
    .dp_i   (dp_i),
    .lz_en_i(lz_en_i),
    .seg_no (seg_no),
    .dp_no  (dp_no),
    .an_no  (an_no),
    .frame_o(frame_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       fr;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  logic [6:0] hex_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Reference model: t is the index of the current cycle since the last reset.
  int          t = 0;
  logic [15:0] sh_val = 16'h0;
  logic [3:0]  sh_dp  = 4'h0;
  logic        sh_lz  = 1'b0;

  function automatic exp_t expect_at(int pos);
    exp_t e;
    int   slot, w;
    logic supp;
    slot  = pos / SLOT;
    w     = pos % SLOT;
    e.seg = 7'h7F;
    e.dp  = 1'b1;
    e.an  = 4'hF;
    e.fr  = (pos == BLANK_CYCLES - 1);
    if (w >= BLANK_CYCLES) begin
      supp = sh_lz && (slot > 0) && ((sh_val >> (4 * slot)) == 16'h0);
      e.dp = ~sh_dp[slot];
      if (!supp) begin
        e.an  = ~(4'h1 << slot);
        e.seg = hex_tab[(sh_val >> (4 * slot)) & 16'hF];
      end
    end
    return e;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      t      = 0;
      sh_val = 16'h0;
      sh_dp  = 4'h0;
      sh_lz  = 1'b0;
    end else begin
      if ((t % FRAME) == BLANK_CYCLES - 1) begin
        sh_val = value_i;
        sh_dp  = dp_i;
        sh_lz  = lz_en_i;
      end
      t = t + 1;
    end
    exp_q.push_back(expect_at(t % FRAME));
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [3:0] prev_an = 4'hF;
  int         since_fr = -1;

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("seg_no", int'(seg_no), int'(e.seg));
      chk("dp_no", int'(dp_no), int'(e.dp));
      chk("an_no", int'(an_no), int'(e.an));
      chk("frame_o", int'(frame_o), int'(e.fr));
      chk("an_one_low", int'($countones(~an_no) <= 1), 1);
      chk("an_direct_hop", int'(prev_an != 4'hF && an_no != 4'hF && an_no != prev_an), 0);
      chk("seg_lit_blank", int'(an_no == 4'hF && seg_no != 7'h7F), 0);
      prev_an = an_no;
      if (since_fr >= 0) since_fr++;
      if (frame_o) begin
        if (since_fr >= 0) chk("frame_period", since_fr, FRAME);
        since_fr = 0;
      end
      if (rst) since_fr = -1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic align(input int pos);
    for (int i = 0; i < FRAME && (t % FRAME) != pos; i++) step(1);
  endtask

  initial begin
    value_i = 16'h12A8;
    dp_i    = 4'b0100;
    lz_en_i = 1'b0;
    rst     = 1'b1;
    step(3);
    rst = 1'b0;
    step(2 * FRAME);

    value_i = 16'h0005;
    dp_i    = 4'b0000;
    lz_en_i = 1'b1;
    step(2 * FRAME);
    lz_en_i = 1'b0;
    step(2 * FRAME);

    // input change during digit 2 lit phase
    align(2 * SLOT + BLANK_CYCLES + 1);
    value_i = 16'hBEEF;
    dp_i    = 4'b1001;
    step(2 * FRAME);

    // one-cycle reset in the middle of digit 3 lit phase
    align(3 * SLOT + BLANK_CYCLES + 1);
    rst = 1'b1;
    step(1);
    rst     = 1'b0;
    value_i = 16'h0070;
    lz_en_i = 1'b1;
    step(2 * FRAME);

    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        value_i = 16'($urandom);
        if ($urandom_range(0, 1) == 0) value_i[15:8] = 8'h00;
        dp_i    = 4'($urandom);
        lz_en_i = 1'($urandom);
      end
      rst = ($urandom_range(0, 299) == 0);
      step(1);
    end
    rst = 1'b0;
    step(FRAME);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
